// File: rtl/renewable_conv_avg_logger.sv
// Multi-channel gain, block-average and saturate; results queued {chan,data,sat} on a FWFT valid/ready stream.
// Result visible one edge after the completing accept; in_ready reserves room for the in-flight sample.

module renewable_conv_avg_logger_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_dat,
    input  logic             i_pop,
    output logic             o_vld,
    output logic [W-1:0]     o_dat,
    output logic [CNT_W-1:0] o_count
);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr, r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_vld   = (r_count != '0);
    assign o_dat   = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_dat;
                r_wr <= (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) r_rd <= (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            if (i_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && w_pop) r_count <= r_count - 1'b1;
        end
    end
endmodule

module renewable_conv_avg_logger #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 8,
    parameter int CHANNELS   = 4,
    parameter int GAIN_W     = 4,
    parameter int GAIN_RESET = 2,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_chan,
    input  logic [IN_W-1:0]   in_data,
    input  logic              gain_we,
    input  logic [CH_W-1:0]   gain_chan,
    input  logic [GAIN_W-1:0] gain_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_chan,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic [7:0]        sat_cnt
);
    localparam int PROD_W = IN_W + GAIN_W;
    localparam int SUM_W  = PROD_W + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [CH_W-1:0]  chan;
        logic [OUT_W-1:0] data;
        logic             sat;
    } res_t;

    logic [GAIN_W-1:0] r_gain [CHANNELS];
    logic [SUM_W-1:0]  r_acc  [CHANNELS];
    logic [CNT_W-1:0]  r_cnt  [CHANNELS];
    logic              r_s1_vld;
    logic [CH_W-1:0]   r_s1_chan;
    logic [PROD_W-1:0] r_s1_prod;
    logic [7:0]        r_sat_cnt;

    logic              w_in_ok, w_gain_ok, w_accept, w_done, w_sat, w_push;
    logic [GAIN_W-1:0] w_gain_rd;
    logic [PROD_W-1:0] w_prod, w_avg;
    logic [SUM_W-1:0]  w_sum;
    logic [OUT_W-1:0]  w_data;
    logic [FCNT_W-1:0] w_fifo_cnt;
    res_t              w_push_dat, w_head;

    // Channel indices beyond CHANNELS only exist when CHANNELS is not a power of two
    if ((1 << CH_W) == CHANNELS) begin : g_full_ch
        assign w_in_ok   = 1'b1;
        assign w_gain_ok = 1'b1;
    end else begin : g_part_ch
        localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);
        assign w_in_ok   = ({1'b0, in_chan} < CH_LIM);
        assign w_gain_ok = ({1'b0, gain_chan} < CH_LIM);
    end

    assign w_accept  = in_valid && in_ready;
    assign w_gain_rd = w_in_ok ? r_gain[in_chan] : '0;
    assign w_prod    = PROD_W'(in_data) * PROD_W'(w_gain_rd);

    assign w_sum  = r_acc[r_s1_chan] + SUM_W'(r_s1_prod);
    assign w_done = (r_cnt[r_s1_chan] == CNT_W'((1 << AVG_LOG2) - 1));
    assign w_avg  = w_sum[SUM_W-1:AVG_LOG2];
    assign w_push = r_s1_vld && w_done;

    if (OUT_W < PROD_W) begin : g_clip
        assign w_sat = |w_avg[PROD_W-1:OUT_W];
    end else begin : g_noclip
        assign w_sat = 1'b0;
    end
    assign w_data = w_sat ? '1 : OUT_W'(w_avg);

    assign w_push_dat = '{chan: r_s1_chan, data: w_data, sat: w_sat};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_gain[i] <= GAIN_W'(GAIN_RESET);
                r_acc[i]  <= '0;
                r_cnt[i]  <= '0;
            end
            r_s1_vld  <= 1'b0;
            r_s1_chan <= '0;
            r_s1_prod <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (gain_we && w_gain_ok) r_gain[gain_chan] <= gain_val;
            r_s1_vld <= w_accept && w_in_ok;
            if (w_accept) begin
                r_s1_chan <= in_chan;
                r_s1_prod <= w_prod;
            end
            if (r_s1_vld) begin
                if (w_done) begin
                    r_acc[r_s1_chan] <= '0;
                    r_cnt[r_s1_chan] <= '0;
                end else begin
                    r_acc[r_s1_chan] <= w_sum;
                    r_cnt[r_s1_chan] <= r_cnt[r_s1_chan] + 1'b1;
                end
            end
            if (w_push && w_sat && (r_sat_cnt != 8'hFF)) r_sat_cnt <= r_sat_cnt + 8'd1;
        end
    end

    renewable_conv_avg_logger_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_dat   (w_push_dat),
        .i_pop   (out_ready),
        .o_vld   (out_valid),
        .o_dat   (w_head),
        .o_count (w_fifo_cnt)
    );

    // Counting the S1 sample keeps room for a push that is already committed
    assign in_ready = rst_n && ((32'(w_fifo_cnt) + 32'(r_s1_vld)) < 32'(FIFO_DEPTH));
    assign out_chan = w_head.chan;
    assign out_data = w_head.data;
    assign out_sat  = w_head.sat;
    assign sat_cnt  = r_sat_cnt;
endmodule

// File: tb/tb_renewable_conv_avg_logger.sv
// Directed bench for renewable_conv_avg_logger: hand-computed results, latency, saturation, backpressure, reset.
module tb_renewable_conv_avg_logger;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [1:0] in_chan;
    logic [7:0] in_data;
    logic       gain_we;
    logic [1:0] gain_chan;
    logic [3:0] gain_val;
    logic       out_valid, out_ready;
    logic [1:0] out_chan;
    logic [7:0] out_data;
    logic       out_sat;
    logic [7:0] sat_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    renewable_conv_avg_logger dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_data(in_data),
        .gain_we(gain_we), .gain_chan(gain_chan), .gain_val(gain_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_data(out_data), .out_sat(out_sat), .sat_cnt(sat_cnt)
    );

    // Time convention: every task starts and ends 1ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int d);
        int t = 0;
        in_chan  = 2'(ch);
        in_data  = 8'(d);
        in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            step();
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready got 0 required 1 (ch %0d data %0d)", ch, d);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic write_gain(input int ch, input int g);
        gain_we = 1'b1; gain_chan = 2'(ch); gain_val = 4'(g);
        step();
        gain_we = 1'b0;
    endtask

    task automatic get_res(output logic ok, output int ch, output int d, output logic s);
        int t = 0;
        while (!out_valid && t < 200) begin
            step();
            t++;
        end
        ok = out_valid;
        ch = int'(out_chan);
        d  = int'(out_data);
        s  = out_sat;
        if (ok) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_chan = '0; in_data = '0;
        gain_we = 1'b0; gain_chan = '0; gain_val = '0; out_ready = 1'b0;
        repeat (3) step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_chan !== 2'd0 || out_data !== 8'd0 || out_sat !== 1'b0) begin
            errors++; $display("FAIL reset_out_regs: got chan %0d data %0d sat %b required 0 0 0", out_chan, out_data, out_sat);
        end
        checks++; if (sat_cnt !== 8'd0) begin errors++; $display("FAIL reset_sat_cnt: got %0d required 0", sat_cnt); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_legacy();
        logic ok, s; int ch, d;
        repeat (4) send(0, 25);
        get_res(ok, ch, d, s);
        checks++; if (!ok || ch != 0 || d != 50 || s !== 1'b0) begin
            errors++; $display("FAIL legacy_25: got ok %b chan %0d data %0d sat %b required 1 0 50 0", ok, ch, d, s);
        end
        repeat (4) send(0, 45);
        get_res(ok, ch, d, s);
        checks++; if (!ok || ch != 0 || d != 90 || s !== 1'b0) begin
            errors++; $display("FAIL legacy_45: got ok %b chan %0d data %0d sat %b required 1 0 90 0", ok, ch, d, s);
        end
    endtask

    task automatic test_floor_latency();
        logic ok, s; int ch, d;
        send(1, 10); send(1, 20); send(1, 30);
        step();
        send(1, 41);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid got %b required 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_on_time: out_valid got %b required 1", out_valid); end
        get_res(ok, ch, d, s);
        checks++; if (!ok || ch != 1 || d != 50 || s !== 1'b0) begin
            errors++; $display("FAIL floor_avg: got ok %b chan %0d data %0d sat %b required 1 1 50 0", ok, ch, d, s);
        end
    endtask

    task automatic test_saturation();
        logic ok, s; int ch, d;
        write_gain(2, 15);
        repeat (4) send(2, 200);
        get_res(ok, ch, d, s);
        checks++; if (!ok || ch != 2 || d != 255 || s !== 1'b1) begin
            errors++; $display("FAIL sat_result: got ok %b chan %0d data %0d sat %b required 1 2 255 1", ok, ch, d, s);
        end
        checks++; if (sat_cnt !== 8'd1) begin errors++; $display("FAIL sat_cnt_one: got %0d required 1", sat_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 299 * 4; i++) send(2, 200);
        repeat (10) step();
        out_ready = 1'b0;
        checks++; if (sat_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_hold: got %0d required 255", sat_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drained: out_valid got %b required 0", out_valid); end
    endtask

    task automatic test_interleave_gain();
        logic ok, s; int ch, d;
        send(0, 100);
        gain_we = 1'b1; gain_chan = 2'd3; gain_val = 4'd1;
        send(3, 100);
        gain_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, 100);
            send(3, 100);
        end
        get_res(ok, ch, d, s);
        checks++; if (!ok || ch != 0 || d != 200 || s !== 1'b0) begin
            errors++; $display("FAIL interleave_ch0: got ok %b chan %0d data %0d sat %b required 1 0 200 0", ok, ch, d, s);
        end
        get_res(ok, ch, d, s);
        checks++; if (!ok || ch != 3 || d != 125 || s !== 1'b0) begin
            errors++; $display("FAIL interleave_ch3: got ok %b chan %0d data %0d sat %b required 1 3 125 0", ok, ch, d, s);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) repeat (4) send(0, k + 1);
        step();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_full: in_ready %b out_valid %b required 0 1", in_ready, out_valid);
        end
        held = out_data;
        repeat (5) step();
        checks++; if (out_data !== 8'd2 || held !== 8'd2 || out_chan !== 2'd0) begin
            errors++; $display("FAIL bp_stable: got %0d then %0d required 2", held, out_data);
        end
        fork
            begin
                for (int k = 4; k < 20; k++) repeat (4) send(0, k + 1);
            end
            begin
                out_ready = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    int t = 0;
                    while (!out_valid && t < 500) begin
                        step();
                        t++;
                    end
                    checks++;
                    if (!out_valid || out_data !== 8'(2 * (k + 1)) || out_chan !== 2'd0) begin
                        errors++;
                        $display("FAIL bp_order[%0d]: got valid %b data %0d required 1 %0d", k, out_valid, out_data, 2 * (k + 1));
                    end
                    step();
                end
            end
        join
        repeat (4) step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: out_valid got %b required 0", out_valid); end
    endtask

    task automatic test_reset_midop();
        logic ok, s; int ch, d;
        out_ready = 1'b0;
        repeat (4) send(1, 1);
        write_gain(0, 5);
        repeat (3) send(0, 99);
        step();
        rst_n = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b required 0", out_valid); end
        checks++; if (sat_cnt !== 8'd0) begin errors++; $display("FAIL midreset_sat_cnt: got %0d required 0", sat_cnt); end
        rst_n = 1'b1;
        repeat (4) send(0, 45);
        get_res(ok, ch, d, s);
        checks++; if (!ok || ch != 0 || d != 90 || s !== 1'b0) begin
            errors++; $display("FAIL midreset_result: got ok %b chan %0d data %0d sat %b required 1 0 90 0", ok, ch, d, s);
        end
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_single: out_valid got %b required 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_floor_latency();
        test_saturation();
        test_interleave_gain();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
